// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared move directions, PS/2 scancodes and FSM encodings
package game_pkg;

  typedef enum logic [2:0] {
    WAIT  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } directions;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  function automatic directions opposite(input directions d);
    case (d)
      UP:      opposite = DOWN;
      DOWN:    opposite = UP;
      LEFT:    opposite = RIGHT;
      RIGHT:   opposite = LEFT;
      default: opposite = WAIT;
    endcase
  endfunction

endpackage

// File: rtl/ps2_dir_decoder.sv
// rtl/ps2_dir_decoder.sv - turns PS/2 set-2 make codes into direction events
module ps2_dir_decoder
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output logic       dir_valid,
  output directions  dir
);

  logic      break_q, break_d;
  logic      ext_q, ext_d;
  directions code_dir;

  // Arrow keys only count behind an E0 prefix; WASD only without one.
  always_comb begin
    code_dir = WAIT;
    if (ext_q) begin
      case (key_code)
        SC_UP:    code_dir = UP;
        SC_DOWN:  code_dir = DOWN;
        SC_LEFT:  code_dir = LEFT;
        SC_RIGHT: code_dir = RIGHT;
        default:  code_dir = WAIT;
      endcase
    end else begin
      case (key_code)
        SC_W:    code_dir = UP;
        SC_S:    code_dir = DOWN;
        SC_A:    code_dir = LEFT;
        SC_D:    code_dir = RIGHT;
        default: code_dir = WAIT;
      endcase
    end
  end

  always_comb begin
    break_d   = break_q;
    ext_d     = ext_q;
    dir_valid = 1'b0;
    dir       = WAIT;
    if (key_valid) begin
      if (key_code == SC_BREAK) begin
        break_d = 1'b1;
      end else if (key_code == SC_EXT) begin
        ext_d = 1'b1;
      end else begin
        break_d = 1'b0;
        ext_d   = 1'b0;
        if (!break_q && code_dir != WAIT) begin
          dir_valid = 1'b1;
          dir       = code_dir;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      break_q <= 1'b0;
      ext_q   <= 1'b0;
    end else begin
      break_q <= break_d;
      ext_q   <= ext_d;
    end
  end

endmodule

// File: rtl/direction_ctrl.sv
// rtl/direction_ctrl.sv - paces player moves and filters keyboard heading changes
module direction_ctrl
  import game_pkg::*;
#(
  parameter int        MOVE_PERIOD = 6_500_000,
  parameter directions START_DIR   = RIGHT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       start,
  input  logic       game_over,
  output directions  direction,
  output logic       move_tick,
  output directions  heading
);

  localparam int CW = $clog2(MOVE_PERIOD);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  directions     dir_q, dir_d;
  logic          move_tick_q, move_tick_d;
  directions     heading_q, heading_d;
  directions     pending_q, pending_d;
  logic          key_ev;
  directions     key_dir;
  logic          tick;
  directions     ref_dir;

  ps2_dir_decoder u_decoder (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .dir_valid (key_ev),
    .dir       (key_dir)
  );

  assign tick = (state_q == ST_RUN) && (cnt_q == CW'(MOVE_PERIOD - 1));
  // In a tick cycle pending is about to become the heading, so reversal is judged against it.
  assign ref_dir = tick ? pending_q : heading_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = WAIT;
    heading_d = heading_q;
    pending_d = pending_q;
    if (start) begin
      state_d   = ST_RUN;
      cnt_d     = '0;
      heading_d = START_DIR;
      pending_d = START_DIR;
    end else begin
      case (state_q)
        ST_IDLE: cnt_d = '0;
        ST_RUN: begin
          if (game_over) begin
            state_d = ST_STOP;
          end else begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
            if (tick) begin
              dir_d     = pending_q;
              heading_d = pending_q;
            end
            if (key_ev && key_dir != opposite(ref_dir)) begin
              pending_d = key_dir;
            end
          end
        end
        default: ;
      endcase
    end
    move_tick_d = (dir_d != WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dir_q       <= WAIT;
      move_tick_q <= 1'b0;
      heading_q   <= START_DIR;
      pending_q   <= START_DIR;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      move_tick_q <= move_tick_d;
      heading_q   <= heading_d;
      pending_q   <= pending_d;
    end
  end

  assign direction = dir_q;
  assign move_tick = move_tick_q;
  assign heading   = heading_q;

endmodule

// File: tb/tb_direction_ctrl.sv
// tb/tb_direction_ctrl.sv - directed self-checking bench for direction_ctrl
module tb_direction_ctrl;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       start = 1'b0;
  logic       game_over = 1'b0;
  directions  direction;
  logic       move_tick;
  directions  heading;

  int tests = 0;
  int failed = 0;

  direction_ctrl #(.MOVE_PERIOD(4), .START_DIR(RIGHT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .start     (start),
    .game_over (game_over),
    .direction (direction),
    .move_tick (move_tick),
    .heading   (heading)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [7:0] code);
    key_valid = 1'b1;
    key_code  = code;
    cyc();
    key_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Steps until a move is emitted, giving up after 8 cycles (d stays WAIT).
  task automatic wait_move(output directions d, output int n);
    d = WAIT;
    n = 0;
    for (int i = 0; i < 8 && d == WAIT; i++) begin
      cyc();
      n++;
      if (move_tick) d = direction;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(); cyc();
    tests++; if (direction !== WAIT) begin failed++; $display("FAIL reset_dir: got %0d expected %0d", direction, WAIT); end
    tests++; if (move_tick !== 1'b0) begin failed++; $display("FAIL reset_tick: got %0b expected 0", move_tick); end
    tests++; if (heading !== RIGHT) begin failed++; $display("FAIL reset_heading: got %0d expected %0d", heading, RIGHT); end
    tests++; if (dut.state_q !== ST_IDLE) begin failed++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
    rst_n = 1'b1;
    cyc();
    send_key(SC_W);
    for (int i = 0; i < 6; i++) begin
      cyc();
      tests++; if (direction !== WAIT) begin failed++; $display("FAIL idle_dir[%0d]: got %0d expected %0d", i, direction, WAIT); end
    end
    tests++; if (heading !== RIGHT) begin failed++; $display("FAIL idle_heading: got %0d expected %0d", heading, RIGHT); end
    tests++; if (dut.cnt_q !== 2'd0) begin failed++; $display("FAIL idle_cnt: got %0d expected 0", dut.cnt_q); end
  endtask

  task automatic test_periodic();
    directions exp_d;
    do_start();
    for (int i = 1; i <= 12; i++) begin
      cyc();
      exp_d = (i % 4 == 0) ? RIGHT : WAIT;
      tests++; if (direction !== exp_d || move_tick !== (i % 4 == 0)) begin
        failed++; $display("FAIL periodic[%0d]: got dir %0d tick %0b expected dir %0d", i, direction, move_tick, exp_d);
      end
    end
  endtask

  task automatic test_keys();
    directions d;
    int n;
    send_key(SC_A); wait_move(d, n);
    tests++; if (d !== RIGHT) begin failed++; $display("FAIL reverse_drop: got %0d expected %0d", d, RIGHT); end
    send_key(SC_W); wait_move(d, n);
    tests++; if (d !== UP) begin failed++; $display("FAIL turn_up: got %0d expected %0d", d, UP); end
    tests++; if (heading !== UP) begin failed++; $display("FAIL heading_up: got %0d expected %0d", heading, UP); end
    send_key(SC_BREAK); send_key(SC_W); wait_move(d, n);
    tests++; if (d !== UP) begin failed++; $display("FAIL break_w: got %0d expected %0d", d, UP); end
    send_key(SC_BREAK); send_key(SC_A); wait_move(d, n);
    tests++; if (d !== UP) begin failed++; $display("FAIL break_a: got %0d expected %0d", d, UP); end
    send_key(SC_A); wait_move(d, n);
    tests++; if (d !== LEFT) begin failed++; $display("FAIL turn_left: got %0d expected %0d", d, LEFT); end
    send_key(SC_EXT); send_key(SC_DOWN); wait_move(d, n);
    tests++; if (d !== DOWN) begin failed++; $display("FAIL ext_down: got %0d expected %0d", d, DOWN); end
    send_key(SC_LEFT); wait_move(d, n);
    tests++; if (d !== DOWN) begin failed++; $display("FAIL arrow_no_ext: got %0d expected %0d", d, DOWN); end
    send_key(SC_EXT); send_key(SC_A); wait_move(d, n);
    tests++; if (d !== DOWN) begin failed++; $display("FAIL wasd_with_ext: got %0d expected %0d", d, DOWN); end
    send_key(SC_EXT); send_key(SC_LEFT); wait_move(d, n);
    tests++; if (d !== LEFT) begin failed++; $display("FAIL ext_left: got %0d expected %0d", d, LEFT); end
    send_key(SC_W); send_key(SC_S); wait_move(d, n);
    tests++; if (d !== DOWN) begin failed++; $display("FAIL last_wins: got %0d expected %0d", d, DOWN); end
  endtask

  task automatic test_tick_key();
    directions d;
    int n;
    send_key(SC_A); wait_move(d, n);
    tests++; if (d !== LEFT) begin failed++; $display("FAIL tk_setup: got %0d expected %0d", d, LEFT); end
    send_key(SC_W);
    cyc(); cyc();
    send_key(SC_S);
    tests++; if (direction !== UP || move_tick !== 1'b1) begin
      failed++; $display("FAIL tk_emit: got dir %0d tick %0b expected dir %0d", direction, move_tick, UP);
    end
    wait_move(d, n);
    tests++; if (d !== UP || n != 4) begin failed++; $display("FAIL tk_next: got %0d after %0d expected %0d after 4", d, n, UP); end
  endtask

  task automatic test_game_over();
    cyc(); cyc(); cyc();
    game_over = 1'b1;
    cyc();
    tests++; if (direction !== WAIT || move_tick !== 1'b0) begin
      failed++; $display("FAIL go_suppress: got dir %0d tick %0b expected dir %0d", direction, move_tick, WAIT);
    end
    tests++; if (dut.state_q !== ST_STOP) begin failed++; $display("FAIL go_state: got %0d expected %0d", dut.state_q, ST_STOP); end
    cyc();
    game_over = 1'b0;
    send_key(SC_A);
    for (int i = 0; i < 6; i++) begin
      cyc();
      tests++; if (direction !== WAIT) begin failed++; $display("FAIL stop_dir[%0d]: got %0d expected %0d", i, direction, WAIT); end
    end
    tests++; if (heading !== UP || dut.state_q !== ST_STOP) begin
      failed++; $display("FAIL stop_hold: got heading %0d state %0d expected %0d %0d", heading, dut.state_q, UP, ST_STOP);
    end
    game_over = 1'b1;
    do_start();
    game_over = 1'b0;
    tests++; if (dut.state_q !== ST_RUN) begin failed++; $display("FAIL start_wins: got %0d expected %0d", dut.state_q, ST_RUN); end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      tests++; if (direction !== ((i == 4) ? RIGHT : WAIT)) begin
        failed++; $display("FAIL restart[%0d]: got %0d expected %0d", i, direction, (i == 4) ? RIGHT : WAIT);
      end
    end
  endtask

  task automatic test_reset_mid();
    directions d;
    int n;
    cyc(); cyc();
    send_key(SC_EXT);
    cyc();
    tests++; if (direction !== RIGHT) begin failed++; $display("FAIL rm_pre: got %0d expected %0d", direction, RIGHT); end
    rst_n = 1'b0;
    #1;
    tests++; if (direction !== WAIT || move_tick !== 1'b0) begin
      failed++; $display("FAIL rm_async_dir: got dir %0d tick %0b expected dir %0d", direction, move_tick, WAIT);
    end
    tests++; if (dut.state_q !== ST_IDLE) begin failed++; $display("FAIL rm_async_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
    cyc();
    rst_n = 1'b1;
    cyc();
    do_start();
    send_key(SC_UP);
    wait_move(d, n);
    tests++; if (d !== RIGHT) begin failed++; $display("FAIL rm_ext_cleared: got %0d expected %0d", d, RIGHT); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_keys();
    test_tick_key();
    test_game_over();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/direction_ctrl.md
DIRECTION_CTRL -- requirements
Module: direction_ctrl

Interface
REQ-001 The block SHALL have parameter MOVE_PERIOD, default 6_500_000, which is the number of clk cycles between player moves (10 moves/s at 65 MHz).
REQ-002 The block SHALL have parameter START_DIR, default RIGHT, which is the heading loaded at reset and at every game start.
REQ-003 Port clk SHALL be an input, 1 bit, the single system clock; all logic runs on it.
REQ-004 Port rst_n SHALL be an input, 1 bit, the reset; it is asynchronous and active-low.
REQ-005 Port key_valid SHALL be an input, 1 bit, a one-cycle strobe meaning key_code holds a new PS/2 byte.
REQ-006 Port key_code SHALL be an input, 8 bits, a PS/2 set-2 scancode byte.
REQ-007 Port start SHALL be an input, 1 bit, a one-cycle pulse that begins or restarts a game.
REQ-008 Port game_over SHALL be an input, 1 bit, a level signal that freezes movement while high.
REQ-009 Port direction SHALL be an output of type directions; it carries a move command to the control stage.
REQ-010 Port move_tick SHALL be an output, 1 bit, high exactly in the cycles where direction is not WAIT.
REQ-011 Port heading SHALL be an output of type directions, giving the last emitted move direction.

Function
REQ-012 Decoder: W (0x1D) and E0 75 SHALL map to UP; S (0x1B) and E0 72 to DOWN; A (0x1C) and E0 6B to LEFT; D (0x23) and E0 74 to RIGHT.
REQ-013 Decoder: byte 0xF0 SHALL set break_flg; the next non-prefix byte SHALL be discarded and SHALL clear break_flg and ext_flg.
REQ-014 Decoder: byte 0xE0 SHALL set ext_flg; the next non-prefix byte SHALL be decoded as extended and then clear ext_flg.
REQ-015 Decoder: an unmapped code, or a mapped code with the wrong ext_flg, SHALL produce no key event.
REQ-016 The FSM SHALL have states IDLE, RUN and STOP.
REQ-017 In IDLE, direction SHALL be WAIT, the counter SHALL be held at 0, and key events SHALL be ignored.
REQ-018 A start pulse in any state SHALL load heading and pending with START_DIR, clear the counter and enter RUN.
REQ-019 In RUN, the counter SHALL increment each cycle; at MOVE_PERIOD-1 it SHALL wrap to 0 and assert tick.
REQ-020 On tick, the registered outputs SHALL be direction = pending and move_tick = 1 for exactly one cycle, appearing on the cycle after the terminal count; heading SHALL become pending.
REQ-021 A key event in RUN SHALL be written to pending unless it is the opposite of the reference heading; the reference heading is pending in a tick cycle and heading otherwise.
REQ-022 A reversal key SHALL be dropped silently; a key equal to the heading SHALL be accepted as a no-op.
REQ-023 Several keys between ticks SHALL resolve last-accepted-wins.
REQ-024 game_over high in RUN SHALL enter STOP on the next cycle; any tick in that same cycle SHALL be suppressed (direction WAIT).
REQ-025 STOP SHALL output WAIT, freeze the counter and heading, ignore keys, and leave only on start.
REQ-026 If start and game_over are high in the same cycle, start SHALL win.
REQ-027 Outside tick cycles, direction SHALL always be WAIT.

Reset
REQ-028 Asserting rst_n low SHALL immediately set state to IDLE, direction to WAIT, move_tick to 0, counter to 0, heading and pending to START_DIR, and break_flg and ext_flg to 0.
REQ-029 A reset in mid-operation SHALL discard a pending key and any partial prefix sequence.

Structure
REQ-030 The scancode constants (SC_W, SC_A, SC_S, SC_D, SC_UP, SC_DOWN, SC_LEFT, SC_RIGHT, SC_BREAK, SC_EXT) and the function opposite(directions) SHALL live in game_pkg next to directions.
REQ-031 The counter width SHALL be $clog2(MOVE_PERIOD).
REQ-032 Scancode decoding SHALL be a sub-module ps2_dir_decoder with inputs clk, rst_n, key_valid and key_code, and outputs dir_valid and dir.

Verification
REQ-033 With MOVE_PERIOD=4, after reset, start and no keys: direction SHALL be RIGHT once every 4 cycles and WAIT in between.
REQ-034 In RUN with heading RIGHT, key 0x1C (LEFT): the next move SHALL be RIGHT; then 0x1D (UP) SHALL give the next move UP.
REQ-035 Sequence F0 1D: no heading change; sequence E0 72 with heading LEFT: the next move SHALL be DOWN.
REQ-036 Key 0x1B arriving in the same cycle as the terminal count with pending UP: the emitted move SHALL be UP, 0x1B SHALL be dropped, and the next move SHALL be UP.
REQ-037 game_over asserted in the terminal-count cycle: no move SHALL be emitted and the block SHALL be in STOP; a later start SHALL re-emit START_DIR after 4 cycles.
REQ-038 rst_n pulsed low mid-RUN after a pending E0: direction SHALL be WAIT and state IDLE at once, and a following 0x75 SHALL not be treated as extended.
